// File: rtl/comp_stim_checker_pkg.sv
// Shared types and constants for the comparator stimulus checker.
// Holds the FSM encoding, LFSR tap mask, seed and LFSR helpers.
package comp_stim_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Galois taps for x^16+x^14+x^13+x^11+1 (right-shift form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;

  // An all-zero state would lock the LFSR, so fall back to the default
  function automatic logic [15:0] eff_seed(
    input logic [15:0] s
  );
    return (s == 16'h0) ? DEF_SEED : s;
  endfunction

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

endpackage

// File: rtl/comp_stim_checker_lfsr16.sv
// 16-bit Galois LFSR pattern source.
// Reset or load restore the seed; step advances one position.
module lfsr16
  import comp_stim_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next state: reload beats step, hold otherwise
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  // State register with synchronous reset to the seed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/comp_stim_checker.sv
// Drives LFSR operand pairs into an 8-bit comparator and
// checks the returned flags against an ideal unsigned compare.
module comp_stim_checker
  import comp_stim_checker_pkg::*;
#(
  parameter int unsigned N_PAIRS    = 10,
  parameter int unsigned SETTLE_CYC = 1,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] A,
  output logic [7:0] B,
  input  logic       A_great_B,
  input  logic       A_equal_B,
  input  logic       A_less_B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] pair_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [15:0] SEED_EFF = eff_seed(SEED);
  localparam logic [3:0]  SET_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0]  NP       = 8'(N_PAIRS);

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [3:0]  settle_q, settle_d;
  logic [7:0]  pair_q, pair_d;
  logic [7:0]  err_q, err_d;
  logic        step;
  logic [15:0] lfsr_s;
  logic [2:0]  flags;
  logic [2:0]  exp_flags;
  logic        mismatch;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .seed  (SEED_EFF),
    .step  (step),
    .state (lfsr_s)
  );

  // Ideal compare of the registered operands; since the
  // expected vector is one-hot, any non-one-hot flag set
  // also differs from it
  always_comb begin
    flags     = {A_great_B, A_equal_B, A_less_B};
    exp_flags = {a_q > b_q, a_q == b_q, a_q < b_q};
    mismatch  = (flags != exp_flags);
  end

  // Next-state, pair loading and counter updates
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    settle_d = settle_q;
    pair_d   = pair_q;
    err_d    = err_q;
    step     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pair_d   = 8'd0;
          err_d    = 8'd0;
          a_d      = lfsr_s[15:8];
          b_d      = lfsr_s[7:0];
          step     = 1'b1;
          settle_d = 4'd0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (settle_q == SET_LAST) begin
          settle_d = 4'd0;
          state_d  = CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      CHECK: begin
        pair_d = pair_q + 8'd1;
        if (mismatch && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
        if (pair_d == NP) begin
          state_d = DONE;
        end else begin
          a_d      = lfsr_s[15:8];
          b_d      = lfsr_s[7:0];
          step     = 1'b1;
          settle_d = 4'd0;
          state_d  = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      settle_q <= 4'd0;
      pair_q   <= 8'd0;
      err_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      settle_q <= settle_d;
      pair_q   <= pair_d;
      err_q    <= err_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign busy     = (state_q == WAIT) || (state_q == CHECK);
  assign done     = (state_q == DONE);
  assign pass     = done && (err_q == 8'd0);
  assign pair_cnt = pair_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_comp_stim_checker.sv
// Directed bench for comp_stim_checker with a pair scoreboard.
// Flag behaviour is selected per run by flag_mode.
module tb_comp_stim_checker;

  localparam int NP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [7:0] A, B, A2, B2;
  logic       gt, eq, lt;
  logic       busy, done, pass;
  logic       busy2, done2, pass2;
  logic [7:0] pair_cnt, err_cnt;
  logic [7:0] pair_cnt2, err_cnt2;
  int         flag_mode = 0;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] mdl = 16'hACE1;
  logic [15:0] exp_q[$];
  logic [15:0] first_run[$];

  always #5 clk = ~clk;

  comp_stim_checker #(
    .N_PAIRS(NP), .SETTLE_CYC(1), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B),
    .A_great_B(gt), .A_equal_B(eq), .A_less_B(lt),
    .busy(busy), .done(done), .pass(pass),
    .pair_cnt(pair_cnt), .err_cnt(err_cnt)
  );

  comp_stim_checker #(
    .N_PAIRS(NP), .SETTLE_CYC(1), .SEED(16'h0000)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start2),
    .A(A2), .B(B2),
    .A_great_B(A2 > B2), .A_equal_B(A2 == B2),
    .A_less_B(A2 < B2),
    .busy(busy2), .done(done2), .pass(pass2),
    .pair_cnt(pair_cnt2), .err_cnt(err_cnt2)
  );

  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    lt = 1'b0;
    case (flag_mode)
      0: begin
        gt = (A > B);
        eq = (A == B);
        lt = (A < B);
      end
      1: eq = 1'b1;
      default: ;
    endcase
  end

  function automatic logic [15:0] mstep(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int mode, input bit poke,
                     input bit record);
    int e;
    logic [15:0] m;
    e = 0;
    flag_mode = mode;
    for (int k = 0; k < NP; k++) begin
      exp_q.push_back(mdl);
      if (record) first_run.push_back(mdl);
      if (mode == 1 && mdl[15:8] != mdl[7:0]) e++;
      if (mode == 2) e++;
      mdl = mstep(mdl);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    chk("done_clr", 32'(done), 32'd0);
    for (int k = 0; k < NP; k++) begin
      @(negedge clk);
      start = (poke && k == 3);
      if (k == NP - 1) chk("done_early", 32'(done), 32'd0);
      chk("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        m = exp_q.pop_front();
        chk("pair_a", 32'(A), 32'(m[15:8]));
        chk("pair_b", 32'(B), 32'(m[7:0]));
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("pair_cnt", 32'(pair_cnt), NP);
    chk("err_cnt", 32'(err_cnt), 32'(e));
    chk("pass", 32'(pass), 32'(e == 0));
  endtask

  initial begin
    logic [15:0] m;
    int r;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_a", 32'(A), 32'd0);
    chk("rst_b", 32'(B), 32'd0);
    chk("rst_pcnt", 32'(pair_cnt), 32'd0);
    chk("rst_ecnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    chk("idle_hold", 32'(busy), 32'd0);

    // ideal comparator
    run(0, 1'b0, 1'b1);
    m = first_run[NP-1];
    @(negedge clk);
    chk("done_hold_a", 32'(A), 32'(m[15:8]));
    chk("done_hold", 32'(done), 32'd1);

    // equal-only flags, restart from DONE, start poke while busy
    run(1, 1'b1, 1'b0);
    // all flags zero
    run(2, 1'b0, 1'b0);

    // reset mid-run at edge 7
    flag_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_a", 32'(A), 32'd0);
    chk("mid_rst_b", 32'(B), 32'd0);
    chk("mid_rst_pcnt", 32'(pair_cnt), 32'd0);
    chk("mid_rst_ecnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    mdl = 16'hACE1;
    exp_q.delete();
    for (int k = 0; k < NP; k++) exp_q.push_back(first_run[k]);
    r = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NP; k++) begin
      @(negedge clk);
      m = exp_q.pop_front();
      if ({A, B} !== m) r++;
      @(negedge clk);
    end
    chk("replay_miss", 32'(r), 32'd0);
    chk("replay_pass", 32'(pass), 32'd1);

    // zero seed instance
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("seed0_a", 32'(A2), 32'hAC);
    chk("seed0_b", 32'(B2), 32'hE1);
    repeat (2 * NP - 1) @(negedge clk);
    chk("seed0_early", 32'(done2), 32'd0);
    @(negedge clk);
    chk("seed0_done", 32'(done2), 32'd1);
    chk("seed0_pass", 32'(pass2), 32'd1);
    chk("seed0_busy", 32'(busy2), 32'd0);
    chk("seed0_pcnt", 32'(pair_cnt2), NP);
    chk("seed0_ecnt", 32'(err_cnt2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_stim_checker.md
COMP_STIM_CHECKER -- requirements
Module: comp_stim_checker

Interface
REQ-001 SHALL have parameter N_PAIRS, default 10, meaning the number of operand pairs per run (1..255).
REQ-002 SHALL have parameter SETTLE_CYC, default 1, meaning the cycles allowed for comparator outputs to settle (1..15).
REQ-003 SHALL have parameter SEED, default 16'hACE1, meaning the initial LFSR state.
REQ-004 SHALL have one clock and a synchronous, active-high reset (already decided); port list follows:
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle run request.
REQ-008 A  output  8  operand A to comparator under test.
REQ-009 B  output  8  operand B to comparator under test.
REQ-010 A_great_B / A_equal_B / A_less_B  input  1 each  comparator flags returned.
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  run complete, held.
REQ-013 pass  output  1  done and zero errors.
REQ-014 pair_cnt  output  8  pairs checked this run.
REQ-015 err_cnt  output  8  mismatching pairs, saturating.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, CHECK, DONE.
REQ-017 LFSR SHALL be 16-bit Galois, taps x^16+x^14+x^13+x^11+1; a zero SEED SHALL be replaced by 16'hACE1.
REQ-018 A SHALL be loaded from lfsr[15:8] and B from lfsr[7:0]; the LFSR SHALL advance exactly one step per pair loaded.
REQ-019 IDLE or DONE with start=1: on that edge SHALL clear counters, done and pass, load pair 0, and enter WAIT with settle counter = 0.
REQ-020 WAIT SHALL count SETTLE_CYC edges, then enter CHECK; A/B SHALL be stable throughout WAIT and CHECK.
REQ-021 CHECK edge SHALL sample the flags and compare them against the expected values computed from registered A/B (unsigned).
REQ-022 A pair SHALL be an error if the flags are not one-hot or do not match the expected values.
REQ-023 CHECK SHALL increment pair_cnt; if pair_cnt reaches N_PAIRS it SHALL enter DONE, else load the next pair and enter WAIT.
REQ-024 done SHALL rise N_PAIRS*(SETTLE_CYC+1) edges after the start edge.
REQ-025 err_cnt SHALL saturate at 255.
REQ-026 busy SHALL be 1 in WAIT/CHECK only; start SHALL be ignored while busy.
REQ-027 pass SHALL equal done AND (err_cnt==0).
REQ-028 A/B SHALL hold their last pair in DONE.

Reset
REQ-029 rst SHALL take priority over start and all other inputs at any state, including mid-run.
REQ-030 On reset: state IDLE; A=B=0; busy, done, pass = 0; pair_cnt = err_cnt = 0; LFSR = SEED.

Structure
REQ-031 A shared package SHALL hold the state enum, LFSR tap mask, and default seed constant.
REQ-032 The LFSR SHALL be a sub-module named lfsr16 (inputs: clk, rst, load, seed, step; output: 16-bit state).
REQ-033 The expected-flag logic SHALL be inline combinational logic in comp_stim_checker.

Verification
REQ-034 Ideal comparator model, N_PAIRS=10, SETTLE_CYC=1, start pulse -> done after 20 edges; pair_cnt=10, err_cnt=0, pass=1.
REQ-035 Flags tied to A_equal_B=1 and others 0 -> err_cnt equals the count of pairs with A!=B (computed from the LFSR model), pass=0.
REQ-036 All flags tied to 0 -> err_cnt=10, pass=0.
REQ-037 rst asserted at edge 7 of a run -> next cycle busy=0, A=B=0, counters 0; a new start replays an identical pair sequence.
REQ-038 start pulsed while busy -> no effect, done still at edge 20; start in DONE -> done clears and a new run continues the LFSR sequence.
REQ-039 SEED=0 -> first pair A=8'hAC, B=8'hE1.
